// File: rtl/button_conditioner.sv
// Per-button 2-FF synchronizer and counter debounce with registered level and press/release pulses.
// Define BUTTON_CONDITIONER_REPEAT_EN to add auto-repeat pulses while a button stays held.
module button_conditioner #(
    parameter int unsigned N_BUT            = 3,
    parameter int unsigned DEBOUNCE_CYC     = 1000000,
    parameter int unsigned REPEAT_DELAY_CYC = 25000000,
    parameter int unsigned REPEAT_RATE_CYC  = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BUT-1:0] but_n,
    output logic [N_BUT-1:0] level,
    output logic [N_BUT-1:0] press_pulse,
    output logic [N_BUT-1:0] rel_pulse,
    output logic [N_BUT-1:0] rep_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                           : REPEAT_RATE_CYC;
    localparam int unsigned RC_W = ($clog2(REP_MAX) > 0) ? $clog2(REP_MAX) : 1;
    localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE_CYC - 1);
`endif

    // Reject configurations the counters cannot represent.
    if (DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_cfg_err
        $error("button_conditioner: DEBOUNCE_CYC must be >= 2 and repeat periods >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONF_P  = 2'd1,
        PRESSED = 2'd2,
        CONF_R  = 2'd3
    } state_t;

    logic [N_BUT-1:0] sync1_q;
    logic [N_BUT-1:0] sync2_q;

    // Two-flop synchronizer; idles high to match released buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= but_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < int'(N_BUT); i++) begin : g_but
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             rel_q;
        logic             rel_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        // Debounce FSM: a level change is accepted only after an unbroken run of agreeing samples.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            level_d = level_q;
            unique case (state_q)
                IDLE: begin
                    if (!sync2_q[i]) begin
                        state_d = CONF_P;
                        cnt_d   = '0;
                    end
                end
                CONF_P: begin
                    if (sync2_q[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (sync2_q[i]) begin
                        state_d = CONF_R;
                        cnt_d   = '0;
                    end
                end
                CONF_R: begin
                    if (!sync2_q[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            level_d = (state_d == PRESSED) || (state_d == CONF_R);
        end

        assign level[i]       = level_q;
        assign press_pulse[i] = press_q;
        assign rel_pulse[i]   = rel_q;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
        logic [RC_W-1:0] rc_q;
        logic [RC_W-1:0] rc_d;
        logic            ph_q;
        logic            ph_d;
        logic            rep_q;
        logic            rep_d;

        // Repeat timer: runs only in PRESSED, holds in CONF_R, clears in IDLE.
        always_comb begin
            rc_d  = rc_q;
            ph_d  = ph_q;
            rep_d = 1'b0;
            if (state_q == IDLE) begin
                rc_d = '0;
                ph_d = 1'b0;
            end else if (state_q == PRESSED) begin
                if (rc_q == (ph_q ? RATE_LAST : DELAY_LAST)) begin
                    rc_d  = '0;
                    ph_d  = 1'b1;
                    rep_d = 1'b1;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rc_q  <= '0;
                ph_q  <= 1'b0;
                rep_q <= 1'b0;
            end else begin
                rc_q  <= rc_d;
                ph_q  <= ph_d;
                rep_q <= rep_d;
            end
        end

        assign rep_pulse[i] = rep_q;
`else
        assign rep_pulse[i] = 1'b0;
`endif
    end

endmodule
